// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Drives one digit at a time with a blanking gap between digits. The digit bus
// is captured once per frame, so a frame never shows a mix of old and new values.
module seg_scan_ctrl #(
  parameter int unsigned N_DIG     = 8,
  parameter int unsigned ON_CYC    = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic                 clk_input,
  input  logic                 rst,
  input  logic                 display_en,
  input  logic [4*N_DIG-1:0]   digits_in,
  input  logic [N_DIG-1:0]     dp_in,
  input  logic [N_DIG-1:0]     en_mask,
  input  logic                 lz_blank,
  output logic [N_DIG-1:0]     an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic                 frame_done
);

  localparam int unsigned CNT_MAX  = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W    = $clog2(N_DIG);
  localparam logic [6:0]  SEG_DARK = 7'h7F;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;

  // Per-frame snapshot of the inputs
  logic [3:0]         snap_dig [N_DIG];
  logic [N_DIG-1:0]   snap_dp;
  logic [N_DIG-1:0]   snap_en;
  logic               snap_lz;

  logic               blank_last_c;
  logic               drive_last_c;
  logic               idx_last_c;
  logic               snap_load_c;
  logic [N_DIG-1:0]   lz_mask_c;
  logic               seen_nz;
  logic [N_DIG-1:0]   drv_an_c;
  logic [6:0]         drv_seg_c;
  logic               drv_dp_c;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show nothing
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_DARK;
    endcase
  endfunction

  // Slot-end and frame-start conditions
  always_comb begin
    blank_last_c = (cnt == CNT_W'(BLANK_CYC - 1));
    drive_last_c = (cnt == CNT_W'(ON_CYC - 1));
    idx_last_c   = (idx == IDX_W'(N_DIG - 1));
    snap_load_c  = display_en &&
                   ((state == S_OFF) ||
                    ((state == S_DRIVE) && drive_last_c && idx_last_c));
  end

  // Leading-zero mask: zeros above the highest nonzero digit; digit 0 always shown
  always_comb begin
    lz_mask_c = '0;
    seen_nz   = 1'b0;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      if (snap_dig[k] != 4'd0) seen_nz = 1'b1;
      lz_mask_c[k] = snap_lz && !seen_nz;
    end
  end

  // Pin values for the digit selected by idx
  always_comb begin
    drv_an_c = '1;
    if (snap_en[idx]) drv_an_c[idx] = 1'b0;
    drv_seg_c = lz_mask_c[idx] ? SEG_DARK : bcd_to_seg(snap_dig[idx]);
    drv_dp_c  = ~snap_dp[idx];
  end

  // Snapshot register, reloaded only at frame start
  always_ff @(posedge clk_input or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_DIG; k++) snap_dig[k] <= 4'd0;
      snap_dp <= '0;
      snap_en <= '0;
      snap_lz <= 1'b0;
    end else if (snap_load_c) begin
      for (int k = 0; k < N_DIG; k++) snap_dig[k] <= digits_in[4*k +: 4];
      snap_dp <= dp_in;
      snap_en <= en_mask;
      snap_lz <= lz_blank;
    end
  end

  // Scan FSM with registered pin outputs
  always_ff @(posedge clk_input or posedge rst) begin
    if (rst) begin
      state      <= S_OFF;
      idx        <= '0;
      cnt        <= '0;
      an         <= '1;
      seg        <= SEG_DARK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!display_en) begin
        state <= S_OFF;
        idx   <= '0;
        cnt   <= '0;
        an    <= '1;
        seg   <= SEG_DARK;
        dp    <= 1'b1;
      end else begin
        case (state)
          S_OFF: begin
            state <= S_BLANK;
            idx   <= '0;
            cnt   <= '0;
            an    <= '1;
            seg   <= SEG_DARK;
            dp    <= 1'b1;
          end
          S_BLANK: begin
            if (blank_last_c) begin
              state <= S_DRIVE;
              cnt   <= '0;
              an    <= drv_an_c;
              seg   <= drv_seg_c;
              dp    <= drv_dp_c;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_DRIVE: begin
            if (drive_last_c) begin
              state <= S_BLANK;
              cnt   <= '0;
              an    <= '1;
              seg   <= SEG_DARK;
              dp    <= 1'b1;
              if (idx_last_c) begin
                idx        <= '0;
                frame_done <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= S_OFF;
            idx   <= '0;
            cnt   <= '0;
            an    <= '1;
            seg   <= SEG_DARK;
            dp    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIG=4, ON_CYC=5, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        display_en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_mask;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_ctrl #(.N_DIG(4), .ON_CYC(5), .BLANK_CYC(2)) dut (
    .clk_input  (clk),
    .rst        (rst),
    .display_en (display_en),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .en_mask    (en_mask),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance n clock edges, landing 2 time units after the last edge
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Dark outputs for n cycles; frame_done expected only on the first one
  task automatic chk_dark(input string tag, input logic fd_first, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".an"},  32'(an), 32'h0000_000F);
      chk({tag, ".seg"}, 32'(seg), 32'h0000_007F);
      chk({tag, ".dp"},  32'(dp), 32'd1);
      chk({tag, ".fd"},  32'(frame_done), (i == 0) ? 32'(fd_first) : 32'd0);
      adv(1);
    end
  endtask

  // Driven digit for n cycles
  task automatic chk_drive(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                           input logic dp_e, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".an"},  32'(an), 32'(an_e));
      chk({tag, ".seg"}, 32'(seg), 32'(seg_e));
      chk({tag, ".dp"},  32'(dp), 32'(dp_e));
      chk({tag, ".fd"},  32'(frame_done), 32'd0);
      chk({tag, ".onehot"}, 32'($countones(~an) <= 1), 32'd1);
      adv(1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    display_en = 1'b1;
    digits_in  = 16'h1234;
    dp_in      = 4'b0100;
    en_mask    = 4'hF;
    lz_blank   = 1'b0;
    #12;
    chk("rst.an",  32'(an), 32'h0000_000F);
    chk("rst.seg", 32'(seg), 32'h0000_007F);
    chk("rst.dp",  32'(dp), 32'd1);
    chk("rst.fd",  32'(frame_done), 32'd0);
    rst = 1'b0;
    adv(1);

    // Frame A: 1234, dp on digit 2
    chk_dark("A.b0", 1'b0, 2);  chk_drive("A.d0", 4'hE, 7'h19, 1'b1, 5);
    chk_dark("A.b1", 1'b0, 2);  chk_drive("A.d1", 4'hD, 7'h30, 1'b1, 5);
    chk_dark("A.b2", 1'b0, 2);  chk_drive("A.d2", 4'hB, 7'h24, 1'b0, 5);
    chk_dark("A.b3", 1'b0, 2);
    lz_blank = 1'b1; digits_in = 16'h0050; dp_in = 4'b0000;
    chk_drive("A.d3", 4'h7, 7'h79, 1'b1, 5);

    // Frame B: 0050 with leading-zero blanking
    chk_dark("B.b0", 1'b1, 2);  chk_drive("B.d0", 4'hE, 7'h40, 1'b1, 5);
    chk_dark("B.b1", 1'b0, 2);  chk_drive("B.d1", 4'hD, 7'h12, 1'b1, 5);
    chk_dark("B.b2", 1'b0, 2);  chk_drive("B.d2", 4'hB, 7'h7F, 1'b1, 5);
    chk_dark("B.b3", 1'b0, 2);
    digits_in = 16'h0000;
    chk_drive("B.d3", 4'h7, 7'h7F, 1'b1, 5);

    // Frame C: all zeros, only digit 0 lit
    chk_dark("C.b0", 1'b1, 2);  chk_drive("C.d0", 4'hE, 7'h40, 1'b1, 5);
    chk_dark("C.b1", 1'b0, 2);  chk_drive("C.d1", 4'hD, 7'h7F, 1'b1, 5);
    chk_dark("C.b2", 1'b0, 2);  chk_drive("C.d2", 4'hB, 7'h7F, 1'b1, 5);
    chk_dark("C.b3", 1'b0, 2);
    lz_blank = 1'b0; digits_in = 16'h1234;
    chk_drive("C.d3", 4'h7, 7'h7F, 1'b1, 5);

    // Frame D: inputs change mid-frame, frame keeps showing 1234
    chk_dark("D.b0", 1'b1, 2);  chk_drive("D.d0", 4'hE, 7'h19, 1'b1, 5);
    chk_dark("D.b1", 1'b0, 2);
    digits_in = 16'h9876; en_mask = 4'b1011;
    chk_drive("D.d1", 4'hD, 7'h30, 1'b1, 5);
    chk_dark("D.b2", 1'b0, 2);  chk_drive("D.d2", 4'hB, 7'h24, 1'b1, 5);
    chk_dark("D.b3", 1'b0, 2);  chk_drive("D.d3", 4'h7, 7'h79, 1'b1, 5);

    // Frame E: 9876, digit 2 masked off
    chk_dark("E.b0", 1'b1, 2);  chk_drive("E.d0", 4'hE, 7'h02, 1'b1, 5);
    chk_dark("E.b1", 1'b0, 2);  chk_drive("E.d1", 4'hD, 7'h78, 1'b1, 5);
    chk_dark("E.b2", 1'b0, 2);
    en_mask = 4'hF;
    chk_drive("E.d2", 4'hF, 7'h00, 1'b1, 5);
    chk_dark("E.b3", 1'b0, 2);  chk_drive("E.d3", 4'h7, 7'h10, 1'b1, 5);

    // Frame F: disable during digit 2, then re-enable
    chk_dark("F.b0", 1'b1, 2);  chk_drive("F.d0", 4'hE, 7'h02, 1'b1, 5);
    chk_dark("F.b1", 1'b0, 2);  chk_drive("F.d1", 4'hD, 7'h78, 1'b1, 5);
    chk_dark("F.b2", 1'b0, 2);  chk_drive("F.d2", 4'hB, 7'h00, 1'b1, 2);
    display_en = 1'b0;
    adv(1);
    chk_dark("off", 1'b0, 3);
    display_en = 1'b1;
    adv(1);
    chk_dark("re.b0", 1'b0, 2); chk_drive("re.d0", 4'hE, 7'h02, 1'b1, 2);

    // Asynchronous reset mid-drive
    rst = 1'b1;
    #1;
    chk("arst.an",  32'(an), 32'h0000_000F);
    chk("arst.seg", 32'(seg), 32'h0000_007F);
    chk("arst.dp",  32'(dp), 32'd1);
    chk("arst.fd",  32'(frame_done), 32'd0);
    #2;
    rst = 1'b0;
    adv(1);
    chk_dark("pr.b0", 1'b0, 2); chk_drive("pr.d0", 4'hE, 7'h02, 1'b1, 5);
    chk_dark("pr.b1", 1'b0, 2); chk_drive("pr.d1", 4'hD, 7'h78, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
